udp_box_packer: RTL and testbench

UDP_BOX_PACKER -- requirements
Module: udp_box_packer

---
 rtl/udp_box_packer_pkg.sv | 29 ++
 rtl/udp_box_packer_if.sv | 15 +
 rtl/udp_box_packer_box_pack_720p.sv | 43 ++++
 rtl/udp_box_packer.sv | 138 +++++++++++++
 tb/tb_udp_box_packer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_box_packer_pkg.sv
// udp_box_pkg: shared definitions for the UDP box packer.
//   - seg_width() : bits per packed box segment
//   - num_bytes() : payload length in bytes (zero-padded to a whole byte)
//   - HDR_BYTE    : first byte of the optional header
//   - HDR_LEN     : number of header bytes in front of the payload
//   - state_t     : packer FSM states
// Optional feature macro: UDP_BOX_PACKER_HDR_EN (adds the HDR state and a
// two-byte header {8'hA5, N_BOX[7:0]} ahead of the payload).
package udp_box_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

`ifdef UDP_BOX_PACKER_HDR_EN
    localparam int HDR_LEN = 2;
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`else
    localparam int HDR_LEN = 0;
    typedef enum logic [0:0] {IDLE, DATA} state_t;
`endif

    function automatic int seg_width(input int xw, input int yw, input int cdep);
        return 2 * (xw + yw) + 3 * cdep;
    endfunction

    function automatic int num_bytes(input int n_box, input int seg);
        return (n_box * seg + 7) / 8;
    endfunction

endpackage

// File: rtl/udp_box_packer_if.sv
// udp_box_packer_if: byte-stream handshake between the packer and its sink.
//   m_data  [7:0] payload byte
//   m_valid       m_data is valid
//   m_ready       sink accepts the byte (transfer on m_valid && m_ready)
//   m_last        final payload byte
// Modports: master (packer side), slave (sink side).
interface udp_box_packer_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/udp_box_packer_box_pack_720p.sv
// box_pack_720p: combinational packing of one box into a SEG-bit segment.
// Coordinates at or beyond the active area are clamped to its last
// pixel/line; each color channel keeps its C_DEP most significant bits.
// Ports:
//   start_x, end_x [XW-1:0]  box X corners
//   start_y, end_y [YW-1:0]  box Y corners
//   color          [23:0]    {r, g, b}
//   seg            [SEG-1:0] {start_x, start_y, end_x, end_y, r, g, b}
module box_pack_720p
    import udp_box_pkg::*;
#(
    parameter int H_ACT = 1280,
    parameter int V_ACT = 720,
    parameter int C_DEP = 2,
    localparam int XW  = $clog2(H_ACT),
    localparam int YW  = $clog2(V_ACT),
    localparam int SEG = seg_width(XW, YW, C_DEP)
) (
    input  logic [XW-1:0]  start_x,
    input  logic [YW-1:0]  start_y,
    input  logic [XW-1:0]  end_x,
    input  logic [YW-1:0]  end_y,
    input  logic [23:0]    color,
    output logic [SEG-1:0] seg
);

    function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v);
        return (int'(v) >= H_ACT) ? XW'(H_ACT - 1) : v;
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v);
        return (int'(v) >= V_ACT) ? YW'(V_ACT - 1) : v;
    endfunction

    // Only the channel MSBs are packed; the rest of color is dropped.
    logic unused_color;
    assign unused_color = ^color;

    assign seg = {clamp_x(start_x), clamp_y(start_y),
                  clamp_x(end_x),   clamp_y(end_y),
                  color[23 -: C_DEP], color[15 -: C_DEP], color[7 -: C_DEP]};

endmodule

// File: rtl/udp_box_packer.sv
// udp_box_packer: snapshots N_BOX box descriptors on start and streams the
// packed payload out one byte per accepted handshake, LSB byte first.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    snapshot request (ignored while busy)
//   start_xs, end_xs         N_BOX*XW box X corners
//   start_ys, end_ys         N_BOX*YW box Y corners
//   colors                   N_BOX*24 {r,g,b} per box
//   m (udp_box_packer_if)    byte stream master: m_data/m_valid/m_ready/m_last
//   busy                     high from snapshot until the last byte is taken
//   done                     one-cycle pulse after the last byte is taken
// Optional feature macro: UDP_BOX_PACKER_HDR_EN (header bytes A5, N_BOX).
module udp_box_packer
    import udp_box_pkg::*;
#(
    parameter int N_BOX = 1,
    parameter int H_ACT = 1280,
    parameter int V_ACT = 720,
    parameter int C_DEP = 2,
    localparam int XW = $clog2(H_ACT),
    localparam int YW = $clog2(V_ACT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_BOX*XW-1:0] start_xs,
    input  logic [N_BOX*XW-1:0] end_xs,
    input  logic [N_BOX*YW-1:0] start_ys,
    input  logic [N_BOX*YW-1:0] end_ys,
    input  logic [N_BOX*24-1:0] colors,
    udp_box_packer_if.master    m,
    output logic                busy,
    output logic                done
);

    localparam int SEG    = seg_width(XW, YW, C_DEP);
    localparam int NB     = num_bytes(N_BOX, SEG);
    localparam int PAY_W  = N_BOX * SEG;
    localparam int SNAP_W = NB * 8;
    localparam int CW     = $clog2(NB + 2);

    logic [PAY_W-1:0]  pay;
    logic [SNAP_W-1:0] snap;
    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt, idx;
    logic              load, done_nxt, is_last;

    for (genvar i = 0; i < N_BOX; i++) begin : g_box
        box_pack_720p #(
            .H_ACT (H_ACT),
            .V_ACT (V_ACT),
            .C_DEP (C_DEP)
        ) u_box (
            .start_x (start_xs[i*XW +: XW]),
            .start_y (start_ys[i*YW +: YW]),
            .end_x   (end_xs[i*XW +: XW]),
            .end_y   (end_ys[i*YW +: YW]),
            .color   (colors[i*24 +: 24]),
            .seg     (pay[i*SEG +: SEG])
        );
    end

    // Snapshot register: data only, contents are irrelevant until loaded.
    always_ff @(posedge clk) begin
        if (load) begin
            snap <= SNAP_W'(pay);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    // cnt counts every byte of the transfer, header included; idx is the
    // payload byte index.
    assign idx  = cnt - CW'(HDR_LEN);
    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        done_nxt  = 1'b0;
        is_last   = 1'b0;
        m.m_valid = 1'b0;
        m.m_data  = '0;
        m.m_last  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_nxt = '0;
`ifdef UDP_BOX_PACKER_HDR_EN
                    state_nxt = HDR;
`else
                    state_nxt = DATA;
`endif
                end
            end
`ifdef UDP_BOX_PACKER_HDR_EN
            HDR: begin
                m.m_valid = 1'b1;
                m.m_data  = (cnt == '0) ? HDR_BYTE : 8'(N_BOX);
                if (m.m_ready) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CW'(HDR_LEN - 1)) begin
                        state_nxt = DATA;
                    end
                end
            end
`endif
            DATA: begin
                is_last   = (idx == CW'(NB - 1));
                m.m_valid = 1'b1;
                m.m_data  = snap[{idx, 3'b000} +: 8];
                m.m_last  = is_last;
                if (m.m_ready) begin
                    cnt_nxt = cnt + 1'b1;
                    if (is_last) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_udp_box_packer.sv
// tb_udp_box_packer: directed bench for udp_box_packer with three instances
// (N_BOX = 1, 3 and 2). Honors UDP_BOX_PACKER_HDR_EN when defined.
module tb_udp_box_packer;

`ifdef UDP_BOX_PACKER_HDR_EN
    localparam int HOFF = 2;
`else
    localparam int HOFF = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic       start_v [3];
    logic       rdy     [3];
    logic       done_w  [3];
    logic       busy_w  [3];
    logic       vld_w   [3];
    logic       last_w  [3];
    logic [7:0] data_w  [3];

    logic [10:0] xs0, xe0;
    logic [9:0]  ys0, ye0;
    logic [23:0] c0;
    logic [32:0] xs1, xe1;
    logic [29:0] ys1, ye1;
    logic [71:0] c1;
    logic [21:0] xs2, xe2;
    logic [19:0] ys2, ye2;
    logic [47:0] c2;

    udp_box_packer_if b0 ();
    udp_box_packer_if b1 ();
    udp_box_packer_if b2 ();

    assign b0.m_ready = rdy[0];
    assign b1.m_ready = rdy[1];
    assign b2.m_ready = rdy[2];
    assign vld_w[0] = b0.m_valid;
    assign vld_w[1] = b1.m_valid;
    assign vld_w[2] = b2.m_valid;
    assign last_w[0] = b0.m_last;
    assign last_w[1] = b1.m_last;
    assign last_w[2] = b2.m_last;
    assign data_w[0] = b0.m_data;
    assign data_w[1] = b1.m_data;
    assign data_w[2] = b2.m_data;

    udp_box_packer #(.N_BOX(1)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .start_xs(xs0), .end_xs(xe0), .start_ys(ys0), .end_ys(ye0), .colors(c0),
        .m(b0), .busy(busy_w[0]), .done(done_w[0])
    );
    udp_box_packer #(.N_BOX(3)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .start_xs(xs1), .end_xs(xe1), .start_ys(ys1), .end_ys(ye1), .colors(c1),
        .m(b1), .busy(busy_w[1]), .done(done_w[1])
    );
    udp_box_packer #(.N_BOX(2)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]),
        .start_xs(xs2), .end_xs(xe2), .start_ys(ys2), .end_ys(ye2), .colors(c2),
        .m(b2), .busy(busy_w[2]), .done(done_w[2])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Capture of accepted bytes and hold checks during stalls
    logic [7:0] cap_d [$];
    logic       cap_l [$];
    int         vcyc  [3];
    logic       stall_p [3];
    logic [7:0] pd [3];
    logic       pl [3];

    task automatic mon(input int k, input logic v, input logic r, input logic l, input logic [7:0] d);
        if (stall_p[k]) begin
            chk($sformatf("hold_valid%0d", k), v, 1'b1);
            chk($sformatf("hold_data%0d", k), d, pd[k]);
            chk($sformatf("hold_last%0d", k), l, pl[k]);
        end
        if (v) vcyc[k]++;
        if (v && r) begin
            cap_d.push_back(d);
            cap_l.push_back(l);
        end
        stall_p[k] = v && !r && !rst;
        pd[k] = d;
        pl[k] = l;
    endtask

    always @(negedge clk) mon(0, b0.m_valid, b0.m_ready, b0.m_last, b0.m_data);
    always @(negedge clk) mon(1, b1.m_valid, b1.m_ready, b1.m_last, b1.m_data);
    always @(negedge clk) mon(2, b2.m_valid, b2.m_ready, b2.m_last, b2.m_data);

    // Expected stream model
    logic [7:0] exp_d [$];

    function automatic logic [47:0] seg(input int sx, input int sy, input int ex, input int ey,
                                        input logic [23:0] c);
        if (sx > 1279) sx = 1279;
        if (ex > 1279) ex = 1279;
        if (sy > 719) sy = 719;
        if (ey > 719) ey = 719;
        return {11'(sx), 10'(sy), 11'(ex), 10'(ey), c[23:22], c[15:14], c[7:6]};
    endfunction

    task automatic push_hdr(input int n);
        exp_d.delete();
`ifdef UDP_BOX_PACKER_HDR_EN
        exp_d.push_back(8'hA5);
        exp_d.push_back(8'(n));
`endif
    endtask

    task automatic build(input int n, input logic [32:0] xs, input logic [32:0] xe,
                         input logic [29:0] ys, input logic [29:0] ye, input logic [71:0] cs);
        logic [143:0] p;
        p = '0;
        push_hdr(n);
        for (int i = 0; i < n; i++)
            p[i*48 +: 48] = seg(int'(xs[i*11 +: 11]), int'(ys[i*10 +: 10]),
                                int'(xe[i*11 +: 11]), int'(ye[i*10 +: 10]), cs[i*24 +: 24]);
        for (int j = 0; j < n*6; j++) exp_d.push_back(p[j*8 +: 8]);
    endtask

    // Hand-computed single-box payload, byte 0 in bits [7:0]
    task automatic set_exp6(input logic [47:0] bytes);
        push_hdr(1);
        for (int j = 0; j < 6; j++) exp_d.push_back(bytes[j*8 +: 8]);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_count"}, cap_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i < cap_d.size()) begin
                chk($sformatf("%s_byte%0d", tag, i), cap_d[i], exp_d[i]);
                chk($sformatf("%s_last%0d", tag, i), cap_l[i], (i == exp_d.size() - 1));
            end
        end
    endtask

    task automatic run(input int k, input bit toggle, input int restart_at, output int cyc);
        cap_d.delete();
        cap_l.delete();
        vcyc[k] = 0;
        rdy[k] = 1'b1;
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        chk($sformatf("first_valid%0d", k), vld_w[k], 1'b1);
        chk($sformatf("busy_set%0d", k), busy_w[k], 1'b1);
        cyc = 0;
        while (!done_w[k] && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (toggle) rdy[k] = ~rdy[k];
            start_v[k] = (cyc == restart_at);
            // A second request arrives with different box data
            if (cyc == restart_at) begin
                xs1 = ~xs1;
                ys1 = ~ys1;
                c1  = ~c1;
            end
        end
        start_v[k] = 1'b0;
        chk($sformatf("done_seen%0d", k), done_w[k], 1'b1);
        chk($sformatf("busy_clear%0d", k), busy_w[k], 1'b0);
        rdy[k] = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [47:0] pu;
        logic any_last;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            rdy[k] = 1'b1;
            stall_p[k] = 1'b0;
            vcyc[k] = 0;
        end
        xs0 = '0; xe0 = '0; ys0 = '0; ye0 = '0; c0 = '0;
        xs1 = '0; xe1 = '0; ys1 = '0; ye1 = '0; c1 = '0;
        xs2 = '0; xe2 = '0; ys2 = '0; ye2 = '0; c2 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), vld_w[k], 1'b0);
            chk($sformatf("rst_last%0d", k), last_w[k], 1'b0);
            chk($sformatf("rst_data%0d", k), data_w[k], 8'h00);
            chk($sformatf("rst_busy%0d", k), busy_w[k], 1'b0);
            chk($sformatf("rst_done%0d", k), done_w[k], 1'b0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Full-frame box, white
        xs0 = 11'd0; ys0 = 10'd0; xe0 = 11'd1279; ye0 = 10'd719; c0 = 24'hFFFFFF;
        set_exp6(48'h0000_04FF_B3FF);
        run(0, 1'b0, -1, cyc);
        compare("full_frame");
        pu = '0;
        if (cap_d.size() >= HOFF + 6)
            for (int j = 0; j < 6; j++) pu[j*8 +: 8] = cap_d[HOFF + j];
        chk("unp_start_x", pu[47:37], 11'd0);
        chk("unp_start_y", pu[36:27], 10'd0);
        chk("unp_end_x", pu[26:16], 11'd1279);
        chk("unp_end_y", pu[15:6], 10'd719);
        chk("unp_color", pu[5:0], 6'h3F);

        // Start in the done cycle, start_x beyond the active width
        chk("done_pulse_b2b", done_w[0], 1'b1);
        xs0 = 11'd2000;
        set_exp6(48'h9FE0_04FF_B3FF);
        run(0, 1'b0, -1, cyc);
        compare("clamp_x");
        @(posedge clk); #1;
        chk("done_one_cycle0", done_w[0], 1'b0);

        // Y clamp and a mixed color
        xs0 = 11'd100; ys0 = 10'd1000; xe0 = 11'd2047; ye0 = 10'd800; c0 = 24'h123456;
        build(1, 33'(xs0), 33'(xe0), 30'(ys0), 30'(ye0), 72'(c0));
        run(0, 1'b0, -1, cyc);
        compare("clamp_y");
        @(posedge clk); #1;

        // Sink stalls every other cycle
        xs0 = 11'd5; ys0 = 10'd7; xe0 = 11'd640; ye0 = 10'd360; c0 = 24'h80C040;
        build(1, 33'(xs0), 33'(xe0), 30'(ys0), 30'(ye0), 72'(c0));
        run(0, 1'b1, -1, cyc);
        compare("stall");
        chk("stall_cycles", vcyc[0], 2 * (6 + HOFF) - 1);
        @(posedge clk); #1;

        // Three boxes; a second start while busy must be ignored
        xs1 = {11'd0, 11'd1500, 11'd10};
        ys1 = {10'd1023, 10'd700, 10'd20};
        xe1 = {11'd2047, 11'd1279, 11'd30};
        ye1 = {10'd0, 10'd719, 10'd40};
        c1  = {24'h0000FF, 24'h00FF00, 24'hFF0000};
        build(3, xs1, xe1, ys1, ye1, c1);
        run(1, 1'b0, 3, cyc);
        compare("three_box");
        @(posedge clk); #1;
        chk("done_one_cycle1", done_w[1], 1'b0);
        chk("restart_ignored", vld_w[1], 1'b0);

        // Reset during the payload
        xs0 = 11'd321; ys0 = 10'd123; xe0 = 11'd999; ye0 = 10'd456; c0 = 24'hA5C3F0;
        cap_d.delete();
        cap_l.delete();
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_valid", vld_w[0], 1'b0);
        chk("abort_busy", busy_w[0], 1'b0);
        chk("abort_done", done_w[0], 1'b0);
        chk("abort_bytes", cap_d.size(), 4);
        any_last = 1'b0;
        foreach (cap_l[i]) any_last |= cap_l[i];
        chk("abort_no_last", any_last, 1'b0);

        // Reset wins over start in the same cycle
        rst = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start_v[0] = 1'b0;
        chk("rst_prio_valid", vld_w[0], 1'b0);
        chk("rst_prio_busy", busy_w[0], 1'b0);
        @(posedge clk); #1;

        build(1, 33'(xs0), 33'(xe0), 30'(ys0), 30'(ye0), 72'(c0));
        run(0, 1'b0, -1, cyc);
        compare("after_abort");
        @(posedge clk); #1;

        // Two boxes
        xs2 = {11'd2047, 11'd640};
        ys2 = {10'd1023, 10'd360};
        xe2 = {11'd1, 11'd1279};
        ye2 = {10'd2, 10'd719};
        c2  = {24'h3F7FBF, 24'hC0C0C0};
        build(2, 33'(xs2), 33'(xe2), 30'(ys2), 30'(ye2), 72'(c2));
        run(2, 1'b0, -1, cyc);
        compare("two_box");
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
